// File: rtl/wb_pkg.sv
// Shared defaults and the queue-entry record for the writeback unit.
package wb_pkg;

    localparam int WB_DATA_W = 64;   // register data width
    localparam int WB_ADDR_W = 5;    // register index width (32 registers)
    localparam int WB_DEPTH  = 4;    // long-latency queue entries, power of two

    // One long-latency result waiting for the register-file write port.
    // valid drops when a younger ALU write to the same register supersedes it.
    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Circular buffer of long-latency results: per-entry valid bit, cancel of every
// entry matching a register index, and youngest-valid-match lookup ports.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH,
    parameter int NLOOK  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_rd,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    input  logic                          cancel,
    input  logic [ADDR_W-1:0]             cancel_rd,
    output logic                          head_valid,
    output logic [ADDR_W-1:0]             head_rd,
    output logic [DATA_W-1:0]             head_data,
    output logic [CNT_W-1:0]              count,
    input  logic [NLOOK-1:0][ADDR_W-1:0]  look_rd,
    output logic [NLOOK-1:0]              look_hit,
    output logic [NLOOK-1:0][DATA_W-1:0]  look_data
);

    // Same layout as wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            ent_reg [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push && (count_reg < CNT_W'(DEPTH));
    assign pop_ok  = pop && (count_reg != '0);

    // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Entry storage and pointers; the push into the tail slot is written last so a
    // same-cycle cancel of that register never hits the (younger) incoming entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cancel && (ent_reg[i].rd == cancel_rd)) begin
                    ent_reg[i].valid <= 1'b0;
                end
            end
            if (pop_ok) begin
                ent_reg[rd_ptr_reg].valid <= 1'b0;
                rd_ptr_reg                <= rd_ptr_reg + 1'b1;
            end
            if (push_ok) begin
                ent_reg[wr_ptr_reg] <= '{valid: 1'b1, rd: push_rd, data: push_data};
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // Popped slots have their valid bit cleared, so valid alone marks live entries.
    assign head_valid = ent_reg[rd_ptr_reg].valid && (count_reg != '0);
    assign head_rd    = ent_reg[rd_ptr_reg].rd;
    assign head_data  = ent_reg[rd_ptr_reg].data;
    assign count      = count_reg;

    generate
        for (genvar gi = 0; gi < NLOOK; gi++) begin : g_look
            logic              hit_c;
            logic [DATA_W-1:0] data_c;
            logic [PTR_W-1:0]  scan_idx;

            // Scan oldest to youngest so the last valid match (the youngest) wins.
            always_comb begin
                hit_c    = 1'b0;
                data_c   = '0;
                scan_idx = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    scan_idx = rd_ptr_reg + PTR_W'(k);
                    if (ent_reg[scan_idx].valid && (ent_reg[scan_idx].rd == look_rd[gi])) begin
                        hit_c  = 1'b1;
                        data_c = ent_reg[scan_idx].data;
                    end
                end
            end

            assign look_hit[gi]  = hit_c;
            assign look_data[gi] = data_c;
        end
    endgenerate

endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter: the ALU owns the single register-file write port; queued
// long-latency results drain whenever the ALU is not writing. Also serves two
// forwarding lookups with ALU-first, then youngest-queued priority.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ll_valid,
    output logic              ll_ready,
    input  logic [ADDR_W-1:0] ll_rd,
    input  logic [DATA_W-1:0] ll_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] fwd_rs1,
    input  logic [ADDR_W-1:0] fwd_rs2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [CNT_W-1:0]  q_count
);

    logic                    alu_wr;
    logic                    q_push;
    logic                    q_pop;
    logic                    head_valid;
    logic [ADDR_W-1:0]       head_rd;
    logic [DATA_W-1:0]       head_data;
    logic [1:0][ADDR_W-1:0]  look_rd;
    logic [1:0]              look_hit;
    logic [1:0][DATA_W-1:0]  look_data;
    logic [1:0]              fwd_hit_c;
    logic [1:0][DATA_W-1:0]  fwd_data_c;

    // Writes to register 0 are meaningless: an ALU op to x0 does not take the port,
    // and a long-latency result to x0 is accepted but never stored.
    assign alu_wr   = alu_valid && (alu_rd != '0);
    assign ll_ready = (q_count < CNT_W'(DEPTH));
    assign q_push   = ll_valid && ll_ready && (ll_rd != '0);
    assign q_pop    = !alu_wr && (q_count != '0);

    wb_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NLOOK  (2)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (q_push),
        .push_rd    (ll_rd),
        .push_data  (ll_data),
        .pop        (q_pop),
        .cancel     (alu_wr),
        .cancel_rd  (alu_rd),
        .head_valid (head_valid),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .count      (q_count),
        .look_rd    (look_rd),
        .look_hit   (look_hit),
        .look_data  (look_data)
    );

    // Write port: ALU first, else the queue head if it has not been cancelled.
    always_comb begin
        RegWrite  = 1'b0;
        rd        = '0;
        writeData = '0;
        if (!rst_n) begin
            RegWrite = 1'b0;
        end else if (alu_wr) begin
            RegWrite  = 1'b1;
            rd        = alu_rd;
            writeData = alu_data;
        end else if (head_valid) begin
            RegWrite  = 1'b1;
            rd        = head_rd;
            writeData = head_data;
        end
    end

    assign look_rd = {fwd_rs2, fwd_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            // The in-flight ALU value is younger than anything queued, so it wins.
            always_comb begin
                fwd_hit_c[gi]  = 1'b0;
                fwd_data_c[gi] = '0;
                if (rst_n && (look_rd[gi] != '0)) begin
                    if (alu_wr && (alu_rd == look_rd[gi])) begin
                        fwd_hit_c[gi]  = 1'b1;
                        fwd_data_c[gi] = alu_data;
                    end else if (look_hit[gi]) begin
                        fwd_hit_c[gi]  = 1'b1;
                        fwd_data_c[gi] = look_data[gi];
                    end
                end
            end
        end
    endgenerate

    assign fwd_hit1  = fwd_hit_c[0];
    assign fwd_hit2  = fwd_hit_c[1];
    assign fwd_data1 = fwd_data_c[0];
    assign fwd_data2 = fwd_data_c[1];

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vector table, reset-in-flight
// sequence and randomized traffic, all checked against a queue-based model.
module tb_writeback_unit;
    import wb_pkg::*;

    localparam int DW    = WB_DATA_W;
    localparam int AW    = WB_ADDR_W;
    localparam int DEPTH = WB_DEPTH;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          ll_valid = 1'b0;
    logic          ll_ready;
    logic [AW-1:0] ll_rd = '0;
    logic [DW-1:0] ll_data = '0;
    logic          RegWrite;
    logic [AW-1:0] rd;
    logic [DW-1:0] writeData;
    logic [AW-1:0] fwd_rs1 = '0;
    logic [AW-1:0] fwd_rs2 = '0;
    logic          fwd_hit1, fwd_hit2;
    logic [DW-1:0] fwd_data1, fwd_data2;
    logic [CW-1:0] q_count;

    always #5 clk = ~clk;

    writeback_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
        .RegWrite(RegWrite), .rd(rd), .writeData(writeData),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .q_count(q_count)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference state: pending long-latency results in age order, oldest first.
    wb_entry_t     mq[$];
    logic [DW-1:0] tb_rf [32];

    // Inputs as seen during the checked cycle, consumed by the model at the edge.
    logic          s_av, s_lv;
    logic [AW-1:0] s_ard, s_lrd;
    logic [DW-1:0] s_ad, s_ld;

    typedef struct {
        logic          av;
        logic [AW-1:0] ard;
        logic [DW-1:0] ad;
        logic          lv;
        logic [AW-1:0] lrd;
        logic [DW-1:0] ld;
        logic [AW-1:0] rs1, rs2;
        logic          we;
        logic [AW-1:0] wrd;
        logic [DW-1:0] wd;
        int            cnt;
        logic          rdy;
        logic          chk_fwd;
        logic          h1, h2;
        logic [DW-1:0] d1, d2;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ll_valid = lv; ll_rd = lrd; ll_data = ld;
        fwd_rs1 = r1; fwd_rs2 = r2;
    endtask

    // Forwarding rule: x0 never hits; a live ALU write wins; else youngest valid queued.
    task automatic model_fwd(input logic [AW-1:0] rs, output logic hit, output logic [DW-1:0] data);
        hit = 1'b0;
        data = '0;
        if (rs != '0) begin
            if (alu_valid && (alu_rd == rs)) begin
                hit = 1'b1;
                data = alu_data;
            end else begin
                for (int i = mq.size() - 1; i >= 0; i--) begin
                    if (mq[i].valid && (mq[i].rd == rs)) begin
                        hit = 1'b1;
                        data = mq[i].data;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic check_cycle();
        logic          aw, e_we, e_rdy, h, hit_x;
        logic [AW-1:0] e_rd;
        logic [DW-1:0] e_wd, d;
        aw = alu_valid && (alu_rd != '0);
        e_rdy = (mq.size() < DEPTH);
        e_we = 1'b0; e_rd = '0; e_wd = '0;
        if (aw) begin
            e_we = 1'b1; e_rd = alu_rd; e_wd = alu_data;
        end else if (mq.size() > 0 && mq[0].valid) begin
            e_we = 1'b1; e_rd = mq[0].rd; e_wd = mq[0].data;
        end
        $display("cyc %0d alu=%0b/%0d ll=%0b/%0d we=%0b rd=%0d wd=%0h cnt=%0d rdy=%0b",
                 cyc, alu_valid, alu_rd, ll_valid, ll_rd, RegWrite, rd, writeData, q_count, ll_ready);
        chk("regwrite", RegWrite, e_we);
        if (e_we) begin
            chk("wr_rd", rd, e_rd);
            chk("wr_data", writeData, e_wd);
        end
        chk("q_count", q_count, mq.size());
        chk("ll_ready", ll_ready, e_rdy);
        model_fwd(fwd_rs1, h, d);
        chk("fwd_hit1", fwd_hit1, h);
        chk("fwd_data1", fwd_data1, d);
        model_fwd(fwd_rs2, hit_x, d);
        chk("fwd_hit2", fwd_hit2, hit_x);
        chk("fwd_data2", fwd_data2, d);
        if (RegWrite) tb_rf[rd] = writeData;
        s_av = alu_valid; s_ard = alu_rd; s_ad = alu_data;
        s_lv = ll_valid; s_lrd = ll_rd; s_ld = ll_data;
    endtask

    // Model edge: drain or cancel existing entries, then append the accepted result.
    task automatic update_model();
        bit aw;
        bit acc;
        wb_entry_t e;
        aw = s_av && (s_ard != '0);
        acc = s_lv && (mq.size() < DEPTH);
        if (!aw && mq.size() > 0) void'(mq.pop_front());
        if (aw) begin
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (e.rd == s_ard) e.valid = 1'b0;
                mq[i] = e;
            end
        end
        if (acc && (s_lrd != '0)) mq.push_back('{valid: 1'b1, rd: s_lrd, data: s_ld});
        cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        update_model();
        #1;
    endtask

    function automatic vec_t mk(input logic av, input int ard, input logic [DW-1:0] ad,
                                input logic lv, input int lrd, input logic [DW-1:0] ld,
                                input logic we, input int wrd, input logic [DW-1:0] wd,
                                input int cnt, input logic rdy);
        vec_t v;
        v.av = av; v.ard = AW'(ard); v.ad = ad;
        v.lv = lv; v.lrd = AW'(lrd); v.ld = ld;
        v.rs1 = '0; v.rs2 = '0;
        v.we = we; v.wrd = AW'(wrd); v.wd = wd;
        v.cnt = cnt; v.rdy = rdy;
        v.chk_fwd = 1'b0; v.h1 = 1'b0; v.h2 = 1'b0; v.d1 = '0; v.d2 = '0;
        return v;
    endfunction

    initial begin
        vec_t v;
        for (int i = 0; i < 32; i++) tb_rf[i] = '0;

        //            av ard ad      lv lrd ld     we wrd wd     cnt rdy
        vt.push_back(mk(0, 0, 0,      1, 5, 'hAA,  0, 0, 0,      0, 1)); // single ll result
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     1, 5, 'hAA,   1, 1));
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     0, 0, 0,      0, 1));
        vt.push_back(mk(1, 1, 'h100,  1, 8, 'h80,  1, 1, 'h100,  0, 1)); // fill while ALU busy
        vt.push_back(mk(1, 1, 'h101,  1, 9, 'h81,  1, 1, 'h101,  1, 1));
        vt.push_back(mk(1, 1, 'h102,  1, 10, 'h82, 1, 1, 'h102,  2, 1));
        vt.push_back(mk(1, 1, 'h103,  1, 11, 'h83, 1, 1, 'h103,  3, 1));
        vt.push_back(mk(1, 1, 'h104,  1, 12, 'h84, 1, 1, 'h104,  4, 0)); // full: offer refused
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     1, 8, 'h80,   4, 0)); // drain in push order
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     1, 9, 'h81,   3, 1));
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     1, 10, 'h82,  2, 1));
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     1, 11, 'h83,  1, 1));
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     0, 0, 0,      0, 1));
        vt.push_back(mk(0, 0, 0,      1, 7, 'h11,  0, 0, 0,      0, 1)); // ALU supersedes queued
        vt.push_back(mk(1, 7, 'h22,   0, 0, 0,     1, 7, 'h22,   1, 1));
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     0, 0, 0,      1, 1)); // cancelled head, silent pop
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     0, 0, 0,      0, 1));
        vt.push_back(mk(0, 0, 0,      1, 3, 'h1,   0, 0, 0,      0, 1)); // two entries for x3
        vt.push_back(mk(1, 2, 'h5,    1, 3, 'h2,   1, 2, 'h5,    1, 1));
        vt.push_back(mk(1, 2, 'h6,    0, 0, 0,     1, 2, 'h6,    2, 1)); // forwarding probe
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     1, 3, 'h1,    2, 1));
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     1, 3, 'h2,    1, 1));
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     0, 0, 0,      0, 1));
        vt.push_back(mk(0, 0, 0,      1, 0, 'h55,  0, 0, 0,      0, 1)); // ll to x0
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     0, 0, 0,      0, 1));
        vt.push_back(mk(1, 4, 'h40,   1, 4, 'h44,  1, 4, 'h40,   0, 1)); // same-cycle push is younger
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     1, 4, 'h44,   1, 1));
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     0, 0, 0,      0, 1));
        vt.push_back(mk(0, 0, 0,      1, 6, 'h66,  0, 0, 0,      0, 1)); // ALU to x0 leaves port free
        vt.push_back(mk(1, 0, 'h99,   0, 0, 0,     1, 6, 'h66,   1, 1));
        vt.push_back(mk(0, 0, 0,      0, 0, 0,     0, 0, 0,      0, 1));
        v = vt[19];
        v.rs1 = 3; v.rs2 = 0; v.chk_fwd = 1'b1;
        v.h1 = 1'b1; v.d1 = 'h2; v.h2 = 1'b0; v.d2 = '0;
        vt[19] = v;

        // Reset state, with live-looking inputs that must not leak through.
        drive(1, 3, 'h33, 1, 4, 'h44, 3, 4);
        @(negedge clk);
        chk("reset_q_count", q_count, 0);
        chk("reset_regwrite", RegWrite, 0);
        chk("reset_fwd_hit1", fwd_hit1, 0);
        chk("reset_fwd_hit2", fwd_hit2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post_reset_ll_ready", ll_ready, 1);
        chk("post_reset_q_count", q_count, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].av, vt[i].ard, vt[i].ad, vt[i].lv, vt[i].lrd, vt[i].ld, vt[i].rs1, vt[i].rs2);
            @(negedge clk);
            check_cycle();
            chk($sformatf("row%0d_we", i), RegWrite, vt[i].we);
            if (vt[i].we) begin
                chk($sformatf("row%0d_rd", i), rd, vt[i].wrd);
                chk($sformatf("row%0d_wd", i), writeData, vt[i].wd);
            end
            chk($sformatf("row%0d_cnt", i), q_count, vt[i].cnt);
            chk($sformatf("row%0d_rdy", i), ll_ready, vt[i].rdy);
            if (vt[i].chk_fwd) begin
                chk($sformatf("row%0d_hit1", i), fwd_hit1, vt[i].h1);
                chk($sformatf("row%0d_data1", i), fwd_data1, vt[i].d1);
                chk($sformatf("row%0d_hit2", i), fwd_hit2, vt[i].h2);
                chk($sformatf("row%0d_data2", i), fwd_data2, vt[i].d2);
            end
            @(posedge clk);
            update_model();
            #1;
        end

        chk("rf_x7_final", tb_rf[7], 'h22);
        chk("rf_x3_final", tb_rf[3], 'h2);
        chk("rf_x4_final", tb_rf[4], 'h44);
        chk("rf_x5_final", tb_rf[5], 'hAA);

        // Reset with three entries queued: nothing may be written afterwards.
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 'h7, 1, AW'(13 + k), DW'(32'h130 + k), 0, 0);
            cycle();
        end
        drive(1, 13, 'hD0, 0, 0, 0, 13, 0);
        @(negedge clk);
        chk("pre_reset_q_count", q_count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_q_count", q_count, 0);
        chk("midrst_regwrite", RegWrite, 0);
        chk("midrst_fwd_hit1", fwd_hit1, 0);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 13, 14);
        for (int k = 0; k < 4; k++) cycle();
        chk("rf_x13_untouched", tb_rf[13], 0);
        chk("rf_x15_untouched", tb_rf[15], 0);

        // Randomized traffic over a small register range to force collisions.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) < 4), AW'($urandom_range(0, 7)), {$urandom(), $urandom()},
                  ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 7)), {$urandom(), $urandom()},
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register index width (32 registers).
REQ-003 SHALL have parameter DEPTH, default 4, meaning long-latency queue entries (power of two).
REQ-004 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port alu_valid  input  1  single-cycle result present this cycle.
REQ-007 SHALL have port alu_rd  input  ADDR_W  ALU destination register.
REQ-008 SHALL have port alu_data  input  DATA_W  ALU result.
REQ-009 SHALL have port ll_valid  input  1  long-latency (load/mul) result offered.
REQ-010 SHALL have port ll_ready  output  1  queue can accept.
REQ-011 SHALL have port ll_rd  input  ADDR_W  long-latency destination.
REQ-012 SHALL have port ll_data  input  DATA_W  long-latency result.
REQ-013 SHALL have port RegWrite  output  1  register-file write enable.
REQ-014 SHALL have port rd  output  ADDR_W  register-file write address.
REQ-015 SHALL have port writeData  output  DATA_W  register-file write data.
REQ-016 SHALL have ports fwd_rs1, fwd_rs2  input  ADDR_W  forwarding lookup addresses.
REQ-017 SHALL have ports fwd_hit1, fwd_hit2  output  1  and fwd_data1, fwd_data2  output  DATA_W  forwarding results.
REQ-018 SHALL have port q_count  output  clog2(DEPTH)+1  valid queue entries.

Function
REQ-019 SHALL accept a long-latency result on a posedge where ll_valid && ll_ready; ll_ready = (q_count < DEPTH), independent of ll_valid and of same-cycle pop.
REQ-020 SHALL accept but not enqueue accepted results with ll_rd == 0; SHALL never assert RegWrite with rd == 0.
REQ-021 SHALL give the single write port to the ALU: alu_valid && alu_rd != 0 drives RegWrite=1, rd=alu_rd, writeData=alu_data combinationally, same cycle.
REQ-022 SHALL otherwise present the oldest valid queue entry on the write port combinationally and pop it at that posedge; invalid (cancelled) head entries are popped silently, one per cycle, with RegWrite=0.
REQ-023 SHALL on an ALU write to register R invalidate, at that posedge, every queued entry with rd == R (younger ALU value must win).
REQ-024 SHALL not invalidate an entry enqueued in the same cycle as an ALU write to the same register (the ll entry is younger).
REQ-025 SHALL support simultaneous push and pop: q_count unchanged; push while full is impossible per REQ-019.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; q_count counts slots including cancelled-but-unpopped entries.
REQ-027 SHALL resolve fwd_rsN: 0 -> hit=0, data=0; else ALU write in progress to that register -> ALU data; else youngest valid queue entry matching -> its data; else hit=0, data=0.
REQ-028 SHALL latency: long-latency result accepted at edge N reaches the register file at edge N+1 earliest, delayed one cycle per cycle of alu_valid occupancy.

Reset
REQ-029 SHALL on rst_n low immediately clear pointers, q_count=0 and all entry valid bits; RegWrite=0 and fwd_hit*=0 while in reset; ll_ready=1 after reset.
REQ-030 SHALL discard queued results on reset mid-operation without writing them.

Structure
REQ-031 SHALL place DATA_W, ADDR_W, DEPTH defaults and the queue-entry record (valid, rd, data) in a shared package wb_pkg.
REQ-032 SHALL implement the queue as one sub-module wb_queue (circular buffer with per-entry valid, cancel-by-rd and youngest-match lookup).

Verification
REQ-033 SHALL check: ll push rd=5 data=0xAA, alu idle -> next cycle RegWrite=1 rd=5 writeData=0xAA, q_count back to 0.
REQ-034 SHALL check: 4 ll pushes while alu_valid held high -> q_count=4, ll_ready=0; drop alu_valid -> 4 consecutive writes in push order.
REQ-035 SHALL check: queue holds rd=7 0x11, then ALU writes rd=7 0x22 -> entry cancelled, register 7 ends 0x22, no later write of 0x11.
REQ-036 SHALL check: queue holds rd=3 0x1 and rd=3 0x2, fwd_rs1=3 -> hit1=1 data1=0x2; fwd_rs2=0 -> hit2=0 data2=0.
REQ-037 SHALL check: ll push rd=0 -> accepted, q_count stays 0, RegWrite never asserted.
REQ-038 SHALL check: rst_n pulsed low with 3 entries queued -> q_count=0, RegWrite=0 immediately, no writes after release.
